// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps one imem read in flight, hands {instr, pc+2} to decode.
// Optional macro FETCHQ_BYPASS_EN forwards the returning fetch straight to decode when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc_plus2,
  input  logic        out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
  } entry_t;

  logic [15:0]   fetch_pc_reg;
  logic          inflight_reg;
  logic [15:0]   inflight_pc_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  entry_t        hold_reg;
  entry_t        queue_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          queue_empty;
  logic          issue;
  logic          bypass_active;
  logic          push;
  logic          pop;
  logic [15:0]   redirect_pc;
  entry_t        capture_data;
  entry_t        head;

  assign redirect_pc = redirect_addr & 16'hFFFE;
  assign occupancy   = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign queue_empty = (count_reg == '0);

  // Credit counts the in-flight read too, so a queue slot is always free for every response.
  assign issue = !reset && !redirect && (occupancy < DEPTH_W);

  always_comb begin
    capture_data          = '0;
    capture_data.instr    = imem_rdata;
    capture_data.pc_plus2 = inflight_pc_reg + 16'd2;
  end

`ifdef FETCHQ_BYPASS_EN
  assign bypass_active = queue_empty && inflight_reg && !redirect;
`else
  assign bypass_active = 1'b0;
`endif

  always_comb begin
    head = hold_reg;
    if (!queue_empty) begin
      head = queue_mem[rd_ptr_reg];
    end else if (bypass_active) begin
      head = capture_data;
    end
  end

  assign out_valid    = !queue_empty || bypass_active;
  assign out_instr    = head.instr;
  assign out_pc_plus2 = head.pc_plus2;
  assign imem_req     = issue;
  assign imem_addr    = fetch_pc_reg;

  // A bypassed response that decode takes this edge never lands in the queue.
  assign pop  = !queue_empty && out_ready && !redirect;
  assign push = inflight_reg && !redirect && !(bypass_active && out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      hold_reg        <= '0;
    end else begin
      // Keep whatever decode last saw so the head outputs are stable while empty.
      hold_reg <= head;
      if (redirect) begin
        fetch_pc_reg <= redirect_pc;
        inflight_reg <= 1'b0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        if (issue) begin
          inflight_reg    <= 1'b1;
          inflight_pc_reg <= fetch_pc_reg;
          fetch_pc_reg    <= fetch_pc_reg + 16'd2;
        end else begin
          inflight_reg <= 1'b0;
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr_reg] <= capture_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: transaction-level queue model checked every cycle, plus directed literal checks.
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic [15:0] imem_rdata = 16'h0000;
  logic        out_ready = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc_plus2;

  int total = 0;
  int bad = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus2(out_pc_plus2),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ a[15:8], ~a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: one-cycle latency, data appears shortly after the edge that accepted the request.
  logic        lat_req = 1'b0;
  logic [15:0] lat_addr = 16'h0000;
  always @(negedge clk) begin
    lat_req  = imem_req;
    lat_addr = imem_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rdata = lat_req ? mem_word(lat_addr) : 16'hDEAD;
  end

  // Reference model: a FIFO of fetched words plus the single outstanding fetch.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc = 16'h0000;
  bit          m_inf = 1'b0;
  logic [15:0] m_inf_pc = 16'h0000;
  ent_t        m_last = '0;

  always @(negedge clk) begin
    ent_t show;
    bit   er;
    bit   ev;
    bit   had;
    if (reset) begin
      q.delete();
      m_pc   = 16'h0000;
      m_inf  = 1'b0;
      m_last = '0;
    end
    er = !reset && !redirect && ((q.size() + int'(m_inf)) < DEPTH);
    ev = (q.size() != 0) || (BYP && m_inf && !redirect);
    if (q.size() != 0) begin
      show = q[0];
    end else if (ev) begin
      show.instr = mem_word(m_inf_pc);
      show.pc2   = m_inf_pc + 16'd2;
    end else begin
      show = m_last;
    end
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("out_instr", {16'd0, out_instr}, {16'd0, show.instr});
    chk("out_pc_plus2", {16'd0, out_pc_plus2}, {16'd0, show.pc2});
    if (!reset) begin
      m_last = show;
      if (redirect) begin
        q.delete();
        m_inf = 1'b0;
        m_pc  = redirect_addr & 16'hFFFE;
      end else begin
        if (ev && out_ready) begin
          $display("xfer pc_plus2=%h instr=%h", show.pc2, show.instr);
        end
        had = (q.size() != 0);
        if (had && out_ready) begin
          void'(q.pop_front());
        end
        if (m_inf && !(BYP && !had && out_ready)) begin
          q.push_back({mem_word(m_inf_pc), m_inf_pc + 16'd2});
        end
        if (er) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 16'd2;
          m_inf    = 1'b1;
        end else begin
          m_inf = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int issues;
    logic [15:0] exp_addr;

    // Reset, free-running fetch.
    reset = 1'b1;
    out_ready = 1'b1;
    cycn(3);
    reset = 1'b0;
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", {16'd0, imem_addr}, 32'h0000);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", {16'd0, out_instr}, 32'h0000);
    cyc();
    #2;
    chk("e0_addr", {16'd0, imem_addr}, 32'h0002);
`ifdef FETCHQ_BYPASS_EN
    chk("e0_valid", {31'd0, out_valid}, 32'd1);
    chk("e0_instr", {16'd0, out_instr}, 32'h00FF);
`else
    chk("e0_valid", {31'd0, out_valid}, 32'd0);
`endif
    cyc();
    #2;
    chk("e1_valid", {31'd0, out_valid}, 32'd1);
`ifdef FETCHQ_BYPASS_EN
    chk("e1_instr", {16'd0, out_instr}, 32'h02FD);
    chk("e1_pc2", {16'd0, out_pc_plus2}, 32'h0004);
`else
    chk("e1_instr", {16'd0, out_instr}, 32'h00FF);
    chk("e1_pc2", {16'd0, out_pc_plus2}, 32'h0002);
`endif
    cycn(8);

    // Back-pressure from reset: exactly DEPTH issues, then one pop frees a credit.
    reset = 1'b1;
    out_ready = 1'b0;
    cycn(2);
    reset = 1'b0;
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (imem_req) issues++;
      cyc();
    end
    chk("bp_issues", 32'(issues), 32'd4);
    #2;
    chk("bp_req_low", {31'd0, imem_req}, 32'd0);
    chk("bp_head", {16'd0, out_instr}, 32'h00FF);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #2;
    chk("bp_req_again", {31'd0, imem_req}, 32'd1);
    chk("bp_next_addr", {16'd0, imem_addr}, 32'h0008);
    chk("bp_head2", {16'd0, out_instr}, 32'h02FD);
    cyc();

    // Redirect with 3 queued and 1 in flight.
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'h0041;
    #2;
    chk("rd_req_low", {31'd0, imem_req}, 32'd0);
    chk("rd_valid_before", {31'd0, out_valid}, 32'd1);
    cyc();
    redirect = 1'b0;
    #2;
    chk("rd_valid_after", {31'd0, out_valid}, 32'd0);
    chk("rd_addr", {16'd0, imem_addr}, 32'h0040);
    chk("rd_req", {31'd0, imem_req}, 32'd1);
    cyc();
    #2;
`ifdef FETCHQ_BYPASS_EN
    chk("rd_first_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_first_pc2", {16'd0, out_pc_plus2}, 32'h0042);
`else
    chk("rd_bubble", {31'd0, out_valid}, 32'd0);
`endif
    cyc();
    #2;
    chk("rd_valid2", {31'd0, out_valid}, 32'd1);
`ifdef FETCHQ_BYPASS_EN
    chk("rd_pc2_2", {16'd0, out_pc_plus2}, 32'h0044);
`else
    chk("rd_first_pc2", {16'd0, out_pc_plus2}, 32'h0042);
`endif
    cycn(3);

    // Redirect near the top of the address space, fetch wraps.
    redirect = 1'b1;
    redirect_addr = 16'hFFFC;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      exp_addr = 16'hFFFC + 16'(2 * i);
      chk("wrap_addr", {16'd0, imem_addr}, {16'd0, exp_addr});
      if (i == (BYP ? 2 : 3)) chk("wrap_pc2", {16'd0, out_pc_plus2}, 32'h0000);
      cyc();
    end
    cycn(2);

    // Asynchronous reset mid-cycle with a full queue.
    out_ready = 1'b0;
    cycn(6);
    #1;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", {16'd0, out_instr}, 32'h0000);
    chk("arst_pc2", {16'd0, out_pc_plus2}, 32'h0000);
    cycn(2);
    reset = 1'b0;
    #2;
    chk("arst_restart_addr", {16'd0, imem_addr}, 32'h0000);
    chk("arst_restart_req", {31'd0, imem_req}, 32'd1);
    out_ready = 1'b1;
    cycn(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
